// File: rtl/rightgrant_sequencer.sv
// rightgrant_sequencer: loads a request vector and serves its set bits
// one at a time, lowest index first, through a valid/ready grant handshake.
// A one-cycle done pulse marks the end of each batch; gnt_count keeps the
// batch total until the next vector is accepted.
module rightgrant_sequencer #(
    parameter int n  = 16,
    parameter int iw = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_valid,
    input  logic [n-1:0]  load_data,
    output logic          load_ready,
    output logic          gnt_valid,
    input  logic          gnt_ready,
    output logic [n-1:0]  gnt_onehot,
    output logic [iw-1:0] gnt_index,
    output logic [iw:0]   gnt_count,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [n-1:0] pend;
    logic [iw:0]  cnt;
    logic         load_acc;
    logic         handshake;

    assign load_acc  = (state == IDLE) && load_valid;
    assign handshake = gnt_valid && gnt_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state: SERVE lingers until pend drains, so an empty batch (or the
    // cycle right after the last handshake) spends one cycle with pend==0.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load_valid) state_next = SERVE;
            SERVE:   if (pend == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; grant is gated so stray ready is harmless
    always_comb begin
        load_ready = (state == IDLE);
        gnt_valid  = (state == SERVE) && (pend != '0);
        done       = (state == DONE);
    end

    // Lowest pending bit: two's-complement isolate trick, zero when pend==0
    always_comb begin
        gnt_onehot = pend & (~pend + 1'b1);
    end

    // Binary index of the one-hot grant (0 when no bit is set)
    always_comb begin
        gnt_index = '0;
        for (int i = 0; i < n; i++) begin
            if (gnt_onehot[i]) gnt_index = iw'(i);
        end
    end

    // Pending vector and batch counter; loads only land while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            cnt  <= '0;
        end else if (load_acc) begin
            pend <= load_data;
            cnt  <= '0;
        end else if (handshake) begin
            pend <= pend & ~gnt_onehot;
            cnt  <= cnt + 1'b1;
        end
    end

    assign gnt_count = cnt;

endmodule
